// File: rtl/fetch_bundle_queue_pkg.sv
// Shared parameters for the fetch bundle queue: PC / bundle widths, the
// packed entry layout and the bit offsets of each field inside an entry.
package fetch_bundle_queue_pkg;

   localparam int SIZE_PC            = 32;
   localparam int INSTRUCTION_BUNDLE = 128;  // four 32-bit instructions
   localparam int FQ_ENTRY_W         = 6*SIZE_PC + INSTRUCTION_BUNDLE + 8;

   // Field LSB offsets inside a packed entry (matches fq_entry_t below).
   localparam int FQ_RAS_LSB  = 0;
   localparam int FQ_TGT3_LSB = FQ_RAS_LSB  + SIZE_PC;
   localparam int FQ_TGT2_LSB = FQ_TGT3_LSB + SIZE_PC;
   localparam int FQ_TGT1_LSB = FQ_TGT2_LSB + SIZE_PC;
   localparam int FQ_TGT0_LSB = FQ_TGT1_LSB + SIZE_PC;
   localparam int FQ_PRED_LSB = FQ_TGT0_LSB + SIZE_PC;
   localparam int FQ_HIT_LSB  = FQ_PRED_LSB + 4;
   localparam int FQ_INSN_LSB = FQ_HIT_LSB  + 4;
   localparam int FQ_PC_LSB   = FQ_INSN_LSB + INSTRUCTION_BUNDLE;

   typedef struct packed {
      logic [SIZE_PC-1:0]            pc;
      logic [INSTRUCTION_BUNDLE-1:0] insn;
      logic [3:0]                    hit;
      logic [3:0]                    pred;
      logic [SIZE_PC-1:0]            tgt0;
      logic [SIZE_PC-1:0]            tgt1;
      logic [SIZE_PC-1:0]            tgt2;
      logic [SIZE_PC-1:0]            tgt3;
      logic [SIZE_PC-1:0]            ras;
   } fq_entry_t;

endpackage

// File: rtl/fetch_bundle_queue_if.sv
// Bundle interface between FetchStage1 (enqueue side), the queue and
// FetchStage2 (dequeue side). slave = queue, master = the surrounding stages.
//   flush_i, enq fields, deqStall_i : into the queue
//   stall_o, valid_o, head fields, count_o : out of the queue
interface fetch_bundle_queue_if
   import fetch_bundle_queue_pkg::*;
#(
   parameter int PTR_W = 2
);
   logic                          flush_i;
   logic                          enqValid_i;
   logic [SIZE_PC-1:0]            pc_i;
   logic [INSTRUCTION_BUNDLE-1:0] instructionBundle_i;
   logic [3:0]                    btbHit_i;
   logic [3:0]                    prediction_i;
   logic [SIZE_PC-1:0]            targetAddr0_i;
   logic [SIZE_PC-1:0]            targetAddr1_i;
   logic [SIZE_PC-1:0]            targetAddr2_i;
   logic [SIZE_PC-1:0]            targetAddr3_i;
   logic [SIZE_PC-1:0]            addrRAS_CP_i;
   logic                          stall_o;
   logic                          deqStall_i;
   logic                          valid_o;
   logic [SIZE_PC-1:0]            pc_o;
   logic [INSTRUCTION_BUNDLE-1:0] instructionBundle_o;
   logic [3:0]                    btbHit_o;
   logic [3:0]                    prediction_o;
   logic [SIZE_PC-1:0]            targetAddr0_o;
   logic [SIZE_PC-1:0]            targetAddr1_o;
   logic [SIZE_PC-1:0]            targetAddr2_o;
   logic [SIZE_PC-1:0]            targetAddr3_o;
   logic [SIZE_PC-1:0]            addrRAS_CP_o;
   logic [PTR_W:0]                count_o;

   modport slave (
      input  flush_i, enqValid_i, pc_i, instructionBundle_i, btbHit_i, prediction_i,
             targetAddr0_i, targetAddr1_i, targetAddr2_i, targetAddr3_i, addrRAS_CP_i,
             deqStall_i,
      output stall_o, valid_o, pc_o, instructionBundle_o, btbHit_o, prediction_o,
             targetAddr0_o, targetAddr1_o, targetAddr2_o, targetAddr3_o, addrRAS_CP_o,
             count_o
   );

   modport master (
      output flush_i, enqValid_i, pc_i, instructionBundle_i, btbHit_i, prediction_i,
             targetAddr0_i, targetAddr1_i, targetAddr2_i, targetAddr3_i, addrRAS_CP_i,
             deqStall_i,
      input  stall_o, valid_o, pc_o, instructionBundle_o, btbHit_o, prediction_o,
             targetAddr0_o, targetAddr1_o, targetAddr2_o, targetAddr3_o, addrRAS_CP_o,
             count_o
   );
endinterface

// File: rtl/fq_entry_ram.sv
// DEPTH x FQ_ENTRY_W register array: one write port, one asynchronous read
// port, whole array cleared to 0 on asynchronous active-low reset.
//   clk, rst_n              : clock / reset
//   we_i, waddr_i, wdata_i  : write port
//   raddr_i, rdata_o        : combinational read port
module fq_entry_ram
   import fetch_bundle_queue_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int PTR_W = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  we_i,
   input  logic [PTR_W-1:0]      waddr_i,
   input  logic [FQ_ENTRY_W-1:0] wdata_i,
   input  logic [PTR_W-1:0]      raddr_i,
   output logic [FQ_ENTRY_W-1:0] rdata_o
);
   logic [DEPTH-1:0][FQ_ENTRY_W-1:0] mem_q, mem_d;

   always_comb begin
      mem_d = mem_q;
      if (we_i) mem_d[waddr_i] = wdata_i;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) mem_q <= '0;
      else        mem_q <= mem_d;
   end

   assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/fetch_bundle_queue.sv
// Decoupling FIFO between FetchStage1 and FetchStage2. Holds whole fetch
// bundles; head entry is presented combinationally, new entries become
// visible one cycle after they are written (no bypass).
//   clk    : clock
//   reset  : asynchronous active-low reset
//   fq     : bundle interface (slave modport) - enqueue fields, flush,
//            dequeue stall, head fields, stall_o (full) and count_o
module fetch_bundle_queue
   import fetch_bundle_queue_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int PTR_W = 2
) (
   input  logic                 clk,
   input  logic                 reset,
   fetch_bundle_queue_if.slave  fq
);
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W:0]   count_q,  count_d;
   logic             full, empty, enq, deq, we;
   fq_entry_t        wr_entry, rd_entry;
   logic [FQ_ENTRY_W-1:0] rd_data;

   // Full/empty come from registered count only, so stall_o never sees deqStall_i.
   assign full  = (count_q == (PTR_W+1)'(DEPTH));
   assign empty = (count_q == '0);
   assign enq   = fq.enqValid_i & ~full;
   assign deq   = ~empty & ~fq.deqStall_i;
   assign we    = enq & ~fq.flush_i;

   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (fq.flush_i) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (enq) wr_ptr_d = wr_ptr_q + 1'b1;  // power-of-2 depth: natural wrap
         if (deq) rd_ptr_d = rd_ptr_q + 1'b1;
         if (enq && !deq)      count_d = count_q + 1'b1;
         else if (deq && !enq) count_d = count_q - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   always_comb begin
      wr_entry.pc   = fq.pc_i;
      wr_entry.insn = fq.instructionBundle_i;
      wr_entry.hit  = fq.btbHit_i;
      wr_entry.pred = fq.prediction_i;
      wr_entry.tgt0 = fq.targetAddr0_i;
      wr_entry.tgt1 = fq.targetAddr1_i;
      wr_entry.tgt2 = fq.targetAddr2_i;
      wr_entry.tgt3 = fq.targetAddr3_i;
      wr_entry.ras  = fq.addrRAS_CP_i;
   end

   fq_entry_ram #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_ram (
      .clk     (clk),
      .rst_n   (reset),
      .we_i    (we),
      .waddr_i (wr_ptr_q),
      .wdata_i (wr_entry),
      .raddr_i (rd_ptr_q),
      .rdata_o (rd_data)
   );

   assign rd_entry = fq_entry_t'(rd_data);

   assign fq.stall_o             = full;
   assign fq.valid_o             = ~empty;
   assign fq.count_o             = count_q;
   assign fq.pc_o                = rd_entry.pc;
   assign fq.instructionBundle_o = rd_entry.insn;
   assign fq.btbHit_o            = rd_entry.hit;
   assign fq.prediction_o        = rd_entry.pred;
   assign fq.targetAddr0_o       = rd_entry.tgt0;
   assign fq.targetAddr1_o       = rd_entry.tgt1;
   assign fq.targetAddr2_o       = rd_entry.tgt2;
   assign fq.targetAddr3_o       = rd_entry.tgt3;
   assign fq.addrRAS_CP_o        = rd_entry.ras;
endmodule

// File: tb/tb_fetch_bundle_queue.sv
// Scoreboard bench: stimulus pushes every bundle that must come out, a
// negedge monitor pops and compares on each dequeue; directed state checks
// cover reset, full/stall, streaming occupancy, flush and async reset.
module tb_fetch_bundle_queue;
   import fetch_bundle_queue_pkg::*;

   logic clk = 1'b0;
   logic reset = 1'b0;
   int   n_chk = 0;
   int   n_pass = 0;
   fq_entry_t sb[$];

   fetch_bundle_queue_if #(.PTR_W(2)) fq_if ();

   fetch_bundle_queue #(.DEPTH(4), .PTR_W(2)) dut (
      .clk   (clk),
      .reset (reset),
      .fq    (fq_if.slave)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [FQ_ENTRY_W-1:0] got,
                      input logic [FQ_ENTRY_W-1:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
   endtask

   // Bundle contents are a fixed function of the PC so every field is traceable.
   function automatic fq_entry_t mk(input logic [31:0] pc);
      fq_entry_t e;
      e.pc   = pc;
      e.insn = {pc ^ 32'hA5A5_0000, pc + 32'd1, pc + 32'd2, pc + 32'd3};
      e.hit  = 4'b0100;
      e.pred = 4'b0100;
      e.tgt0 = pc + 32'h1000;
      e.tgt1 = pc + 32'h2000;
      e.tgt2 = pc + 32'h3000;
      e.tgt3 = pc + 32'h4000;
      e.ras  = pc + 32'd4;
      return e;
   endfunction

   function automatic fq_entry_t head();
      fq_entry_t e;
      e.pc   = fq_if.pc_o;
      e.insn = fq_if.instructionBundle_o;
      e.hit  = fq_if.btbHit_o;
      e.pred = fq_if.prediction_o;
      e.tgt0 = fq_if.targetAddr0_o;
      e.tgt1 = fq_if.targetAddr1_o;
      e.tgt2 = fq_if.targetAddr2_o;
      e.tgt3 = fq_if.targetAddr3_o;
      e.ras  = fq_if.addrRAS_CP_o;
      return e;
   endfunction

   task automatic drive(input logic v, input logic [31:0] pc);
      fq_entry_t e;
      e = mk(pc);
      fq_if.enqValid_i          = v;
      fq_if.pc_i                = e.pc;
      fq_if.instructionBundle_i = e.insn;
      fq_if.btbHit_i            = e.hit;
      fq_if.prediction_i        = e.pred;
      fq_if.targetAddr0_i       = e.tgt0;
      fq_if.targetAddr1_i       = e.tgt1;
      fq_if.targetAddr2_i       = e.tgt2;
      fq_if.targetAddr3_i       = e.tgt3;
      fq_if.addrRAS_CP_i        = e.ras;
   endtask

   // Offer a bundle that must be accepted: remember it for the monitor.
   task automatic enq(input logic [31:0] pc);
      drive(1'b1, pc);
      sb.push_back(mk(pc));
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_state(input string nm, input logic v, input logic s, input int c);
      chk({nm, "_valid"}, FQ_ENTRY_W'(fq_if.valid_o), FQ_ENTRY_W'(v));
      chk({nm, "_stall"}, FQ_ENTRY_W'(fq_if.stall_o), FQ_ENTRY_W'(s));
      chk({nm, "_count"}, FQ_ENTRY_W'(fq_if.count_o), FQ_ENTRY_W'(c));
   endtask

   // Monitor: a dequeue happens at the next edge when valid_o & ~deqStall_i.
   always @(negedge clk) begin
      if (reset && !fq_if.flush_i && fq_if.valid_o && !fq_if.deqStall_i) begin
         if (sb.size() == 0) begin
            n_chk++;
            $display("FAIL deq_unexpected: got pc %0h expected no entry", fq_if.pc_o);
         end else begin
            fq_entry_t e;
            e = sb.pop_front();
            chk("deq_pc", FQ_ENTRY_W'(fq_if.pc_o), FQ_ENTRY_W'(e.pc));
            chk("deq_entry", head(), e);
         end
      end
   end

   initial begin
      fq_if.flush_i    = 1'b0;
      fq_if.deqStall_i = 1'b1;
      drive(1'b0, 32'h0);

      // Reset then idle
      repeat (2) @(posedge clk);
      #1;
      chk_state("in_reset", 1'b0, 1'b0, 0);
      reset = 1'b1;
      step();
      chk_state("post_reset", 1'b0, 1'b0, 0);
      chk("post_reset_data", head(), '0);

      // Fill and drain
      enq(32'h100); step(); chk_state("fill1", 1'b1, 1'b0, 1);
      enq(32'h120); step();
      enq(32'h140); step();
      enq(32'h160); step(); chk_state("full", 1'b1, 1'b1, 4);
      drive(1'b1, 32'h180); step(); chk_state("drop_when_full", 1'b1, 1'b1, 4);
      drive(1'b0, 32'h0);
      fq_if.deqStall_i = 1'b0;
      step(); chk_state("first_deq", 1'b1, 1'b0, 3);
      repeat (3) step();
      chk_state("drained", 1'b0, 1'b0, 0);

      // Streaming: occupancy stays at 1, head lags input by one cycle
      for (int i = 0; i < 6; i++) begin
         enq(32'h200 + 32'h20 * i);
         step();
         chk_state("stream", 1'b1, 1'b0, 1);
      end
      drive(1'b0, 32'h0); step(); chk_state("stream_end", 1'b0, 1'b0, 0);

      // Wrap-around at occupancy 3
      fq_if.deqStall_i = 1'b1;
      for (int i = 0; i < 3; i++) begin enq(32'h400 + 32'h20 * i); step(); end
      chk_state("wrap_prefill", 1'b1, 1'b0, 3);
      fq_if.deqStall_i = 1'b0;
      for (int i = 0; i < 10; i++) begin
         enq(32'h460 + 32'h20 * i);
         step();
         chk_state("wrap", 1'b1, 1'b0, 3);
      end
      drive(1'b0, 32'h0);
      repeat (3) step();
      chk_state("wrap_drained", 1'b0, 1'b0, 0);

      // Flush priority over enq and deq
      fq_if.deqStall_i = 1'b1;
      for (int i = 0; i < 3; i++) begin enq(32'h600 + 32'h20 * i); step(); end
      chk_state("pre_flush", 1'b1, 1'b0, 3);
      fq_if.flush_i    = 1'b1;
      fq_if.deqStall_i = 1'b0;
      drive(1'b1, 32'h700);
      step();
      fq_if.flush_i = 1'b0;
      drive(1'b0, 32'h0);
      sb.delete();
      chk_state("post_flush", 1'b0, 1'b0, 0);
      repeat (2) step();
      chk_state("flush_idle", 1'b0, 1'b0, 0);
      enq(32'h720); step();
      drive(1'b0, 32'h0); step();
      chk_state("after_flush_enq", 1'b0, 1'b0, 0);

      // Asynchronous reset while full
      fq_if.deqStall_i = 1'b1;
      for (int i = 0; i < 4; i++) begin enq(32'h800 + 32'h20 * i); step(); end
      drive(1'b0, 32'h0);
      chk_state("pre_async", 1'b1, 1'b1, 4);
      #3 reset = 1'b0;
      #1;
      chk_state("async_reset", 1'b0, 1'b0, 0);
      chk("async_reset_data", head(), '0);
      sb.delete();
      step();
      reset = 1'b1;
      step();
      chk_state("after_async", 1'b0, 1'b0, 0);

      chk("sb_empty", FQ_ENTRY_W'(sb.size()), '0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/fetch_bundle_queue.md
# fetch_bundle_queue

Decoupling queue between FetchStage1 and FetchStage2. It buffers whole fetch bundles so a downstream stall or an I-cache miss does not directly stall the other side of the front end. Each entry holds the bundle PC, the 4-instruction bundle, the per-slot BTB hit, target and prediction, and the RAS checkpoint address. Its full indication drives FetchStage1's `stall_i`.

## Interface
Parameters:
- `DEPTH`, default 4: number of entries. Must be a power of 2, ≥ 2.
- `PTR_W`, default 2: log2(`DEPTH`).

Ports:
- `clk` input 1: the single clock; all state updates on its rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `flush_i` input 1: synchronous clear of all entries (recovery or exception).
- `enqValid_i` input 1: FetchStage1 bundle valid; driven by `fs1Ready_o`.
- `pc_i` input `SIZE_PC`: bundle PC.
- `instructionBundle_i` input `INSTRUCTION_BUNDLE`: four instructions.
- `btbHit_i` input 4: slot hit bits; bit n is slot n.
- `prediction_i` input 4: slot direction predictions.
- `targetAddr0_i` … `targetAddr3_i` input `SIZE_PC` each: slot targets.
- `addrRAS_CP_i` input `SIZE_PC`: RAS checkpoint address.
- `stall_o` output 1: queue full; connects to FetchStage1 `stall_i`.
- `deqStall_i` input 1: FetchStage2 cannot accept this cycle.
- `valid_o` output 1: head entry is valid.
- `pc_o`, `instructionBundle_o`, `btbHit_o`, `prediction_o`, `targetAddr0_o` … `targetAddr3_o`, `addrRAS_CP_o` output, same widths as the matching inputs: head entry fields.
- `count_o` output `PTR_W+1`: current occupancy.

## Operation
- State:
  - head pointer `rdPtr`, `PTR_W` bits;
  - tail pointer `wrPtr`, `PTR_W` bits;
  - `count`, `PTR_W+1` bits;
  - entry storage, `DEPTH` entries.
- Derived signals:
  - `full` = (`count` == `DEPTH`).
  - `empty` = (`count` == 0).
  - `stall_o` = `full`, decoded from registered state only. There is no combinational path from `deqStall_i` to `stall_o`.
- `enq` = `enqValid_i` & ~`full`. It writes the input fields into entry `wrPtr`; `wrPtr` increments modulo `DEPTH`, with natural wrap.
- `deq` = ~`empty` & ~`deqStall_i`. `rdPtr` increments modulo `DEPTH`.
- `count` update:
  - +1 on `enq` only;
  - −1 on `deq` only;
  - unchanged when `enq` and `deq` occur together.
- Enqueue while full is dropped. This is legal only because FetchStage1 holds its PC while `stall_o` is high.
- The simultaneous enq+deq case is legal at any occupancy below `DEPTH`, including 1.
- `valid_o` = ~`empty`. Head outputs come combinationally from entry `rdPtr`.
- `flush_i` takes priority over `enq` and `deq` in the same cycle. It sets `rdPtr`, `wrPtr` and `count` to 0, and the incoming bundle is discarded.
- Reset (asserted low, asynchronous):
  - pointers and `count` go to 0;
  - all storage goes to 0;
  - so after reset `valid_o`=0, `stall_o`=0, `count_o`=0, and every data output reads 0.
- Reset mid-operation discards all entries immediately, without waiting for a clock edge.
- Storage is not cleared on flush. Head data after a flush is don't-care while `valid_o`=0.

## Timing
- Enqueue-to-head latency is 1 cycle. A bundle written at edge k appears on the outputs with `valid_o`=1 after edge k.
- There is no same-cycle bypass, even when the queue is empty.
- A dequeue at edge k exposes the next entry after edge k.
- `stall_o` rises the cycle after the enqueue that fills the queue. It falls the cycle after the first dequeue from the full state.
- `flush_i` at edge k gives `valid_o`=0 and `stall_o`=0 after edge k.
- Sustained throughput is one bundle per cycle when neither side stalls.

## Structure
- Shared parameter file (alongside `SIZE_PC` and `INSTRUCTION_BUNDLE`) holds `FQ_ENTRY_W` = 6×`SIZE_PC` + `INSTRUCTION_BUNDLE` + 8, together with the field offset macros for packing an entry.
- Sub-module `fq_entry_ram`:
  - `DEPTH`×`FQ_ENTRY_W` register array;
  - one write port and one asynchronous read port;
  - asynchronous active-low reset to 0.
- Pointer, count and flush control live in the top module.

## Test plan
- Reset then idle: `reset` low for 2 cycles, then high → `valid_o`=0, `stall_o`=0, `count_o`=0, all data outputs 0.
- Fill and drain: `deqStall_i`=1, enqueue PCs 0x100, 0x120, 0x140, 0x160 → `stall_o`=1 after the 4th edge and a 5th enqueue (0x180) is dropped. Then `deqStall_i`=0 → `pc_o` reads 0x100, 0x120, 0x140, 0x160 on consecutive cycles, then `valid_o`=0.
- Streaming: `enqValid_i`=1 every cycle with PC stepping by 0x20 and `deqStall_i`=0 → `count_o` stays at 1 and `pc_o` follows the input with a 1-cycle lag.
- Wrap-around: run 10 enq/deq pairs with occupancy held at 3 → output order matches input order exactly across the pointer wrap. Slot fields must match: `btbHit_o`=4'b0100, `prediction_o`=4'b0100 and `targetAddr2_o` as written.
- Flush priority: queue holds 3 entries, then `flush_i`=1 together with `enqValid_i`=1 and `deqStall_i`=0 → next cycle `count_o`=0, `valid_o`=0, and the bundle offered in the flush cycle never appears.
- Async reset mid-run: queue full, then `reset` goes low between edges → `stall_o` and `valid_o` drop to 0 before the next `clk` edge.
